serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder/subtractor built around a single 1-bit
// full adder. Each operation processes one bit per clock, LSB first, over
// WIDTH cycles. The result appears in a registered sum/cout pair and is
// flagged by a one-cycle done pulse.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    // The single full-adder cell; subtraction inverts B and seeds carry with 1
    logic fa_a, fa_b, fa_s, fa_c;

    always_comb begin
        fa_a = a_q[0];
        fa_b = b_q[0] ^ sub_q;
        fa_s = fa_a ^ fa_b ^ carry_q;
        fa_c = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                if (cnt_q == LAST) begin
                    cout_d  = fa_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything including the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): the driver pushes the
// arithmetic result expected for each accepted operation; a monitor pops and
// compares whenever done is seen.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst, start, sub, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned arithmetic
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic ts, input logic tc);
        exp_t        e;
        logic [W:0]  t;
        if (!ts) begin
            t   = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
            e.s = t[W-1:0];
            e.c = t[W];
        end else begin
            e.s = ta - tb;
            e.c = (ta >= tb);
        end
        return e;
    endfunction

    // Monitor: pop/compare on done, check run length and pulse shape
    int   run_len = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        chk("busy_and_done_exclusive", {31'd0, busy & done}, 32'd0);
        if (done) begin
            chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
            chk("busy_run_length", run_len, W);
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sum", {24'd0, sum}, {24'd0, e.s});
                chk("cout", {31'd0, cout}, {31'd0, e.c});
            end
            run_len = 0;
        end else if (busy) begin
            run_len++;
        end else begin
            run_len = 0;
        end
        prev_done = done;
    end

    // Present an operation for one clock and record its expected result
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic ts, input logic tc);
        @(negedge clk);
        a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
        q.push_back(model(ta, tb, ts, tc));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done with a cycle bound, scrambling operand inputs meanwhile
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom);
            sub = 1'($urandom); cin = 1'($urandom);
            cyc++;
        end
        if (!done) chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts, input logic tc);
        int   cyc;
        exp_t e;
        e = model(ta, tb, ts, tc);
        issue(ta, tb, ts, tc);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_done(cyc);
        chk("latency", cyc, W + 1);
        repeat (2) @(negedge clk);
        chk("sum_hold", {24'd0, sum}, {24'd0, e.s});
        chk("cout_hold", {31'd0, cout}, {31'd0, e.c});
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;

        // Reset for two cycles, with start held high on the second
        @(negedge clk);
        a = 8'h05; b = 8'h05; start = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start_with_rst_ignored", {31'd0, busy}, 32'd0);

        // Directed arithmetic cases
        run_op(8'h3C, 8'h42, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b1);
        run_op(8'h80, 8'h80, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 1'b1, 1'b1);
        run_op(8'h20, 8'h10, 1'b1, 1'b0);
        run_op(8'h55, 8'h55, 1'b1, 1'b0);
        run_op(8'h00, 8'hFF, 1'b1, 1'b0);

        // Start re-pulsed during RUN and during DONE must be ignored
        issue(8'h01, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 3;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) chk("done_timeout_repulse", 32'd1, 32'd0);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("repulse_idle", {31'd0, busy}, 32'd0);
        chk("repulse_sum", {24'd0, sum}, 32'h02);
        run_op(8'hAA, 8'h55, 1'b0, 1'b0);

        // Reset after the fourth RUN edge aborts without a done pulse
        issue(8'h33, 8'h44, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        void'(q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_sum", {24'd0, sum}, 32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        repeat (12) @(negedge clk);
        run_op(8'h0F, 8'h01, 1'b0, 1'b0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end

        // Drain: every expected result must have been consumed
        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
